log_int_normalizer: RTL and testbench

//   Upstream stage of the log-compression path. Takes an unsigned DATA_WIDTH envelope sample
//   and finds its leading one with a multi-cycle binary search. Outputs the integer part of
//   log2 (exponent) and a normalized 1.FRAC_WIDTH mantissa in [1,2). The mantissa feeds the

---
 rtl/log_int_normalizer.sv | 129 ++++++++++++
 tb/tb_log_int_normalizer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/log_int_normalizer.sv
// Leading-one detector for the log-compression path: a multi-cycle binary search
// yields floor(log2(data_in)) and a 1.FRAC_WIDTH mantissa for the CORDIC stage.
module log_int_normalizer #(
    parameter int DATA_WIDTH = 48,
    parameter int FRAC_WIDTH = 16,
    parameter int NORM_WIDTH = FRAC_WIDTH + 1,
    parameter int EXP_WIDTH  = $clog2(DATA_WIDTH),
    parameter int STEPS      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NORM_WIDTH-1:0] norm_out,
    output logic [EXP_WIDTH-1:0]  exp_out,
    output logic                  zero_out
);
    localparam int LZ_WIDTH = EXP_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] w_q, w_d;
    logic [LZ_WIDTH-1:0]   lz_q, lz_d;
    logic [EXP_WIDTH-1:0]  k_q, k_d;
    logic                  zero_q, zero_d;
    logic                  out_valid_q, out_valid_d;
    logic [NORM_WIDTH-1:0] norm_q, norm_d;
    logic [EXP_WIDTH-1:0]  exp_q, exp_d;
    logic                  zero_out_q, zero_out_d;

    logic [LZ_WIDTH-1:0]   shift_s;
    logic [DATA_WIDTH-1:0] top_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            w_q         <= '0;
            lz_q        <= '0;
            k_q         <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            norm_q      <= '0;
            exp_q       <= '0;
            zero_out_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            lz_q        <= lz_d;
            k_q         <= k_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            norm_q      <= norm_d;
            exp_q       <= exp_d;
            zero_out_q  <= zero_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        lz_d        = lz_q;
        k_d         = k_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        norm_d      = norm_q;
        exp_d       = exp_q;
        zero_out_d  = zero_out_q;

        // Search window halves each step: 2^(STEPS-1-k) bits from the MSB end.
        shift_s  = LZ_WIDTH'(1) << (EXP_WIDTH'(STEPS - 1) - k_q);
        top_mask = ~({DATA_WIDTH{1'b1}} >> shift_s);

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    w_d         = data_in;
                    lz_d        = '0;
                    k_d         = '0;
                    zero_d      = (data_in == '0);
                    out_valid_d = 1'b0;
                    state_d     = SEARCH;
                end
            end
            SEARCH: begin
                if ((w_q & top_mask) == '0) begin
                    w_d  = w_q << shift_s;
                    lz_d = lz_q + shift_s;
                end
                k_d = k_q + EXP_WIDTH'(1);
                if (k_q == EXP_WIDTH'(STEPS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Gate on out_valid_q so an early out_ready cannot drop the result.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                    if (zero_q) begin
                        exp_d      = '0;
                        norm_d     = NORM_WIDTH'(1) << FRAC_WIDTH;
                        zero_out_d = 1'b1;
                    end else begin
                        exp_d      = EXP_WIDTH'(DATA_WIDTH - 1) - lz_q[EXP_WIDTH-1:0];
                        norm_d     = w_q[DATA_WIDTH-1 -: NORM_WIDTH];
                        zero_out_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign norm_out  = norm_q;
    assign exp_out   = exp_q;
    assign zero_out  = zero_out_q;
endmodule

// File: tb/tb_log_int_normalizer.sv
// Directed bench for log_int_normalizer: vector table plus backpressure and
// mid-search reset sequences.
module tb_log_int_normalizer;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] norm_out;
    logic [5:0]  exp_out;
    logic        zero_out;

    int total = 0;
    int bad   = 0;

    log_int_normalizer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .norm_out  (norm_out),
        .exp_out   (exp_out),
        .zero_out  (zero_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] data;
        logic [5:0]  exp_v;
        logic [16:0] norm_v;
        logic        zero_v;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic accept(input logic [47:0] d, input logic hold_valid);
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = d;
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        if (!hold_valid) in_valid = 1'b0;
    endtask

    // Counts falling edges after the accept edge until out_valid is seen.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            chk("valid_ready_exclusive", 64'(out_valid && in_ready), 64'd0);
        end while (!out_valid && n < 50);
        if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic check_result(input string tag, input vec_t v, input int n);
        chk({tag, "_latency"}, 64'(n), 64'd8);
        chk({tag, "_exp"}, 64'(exp_out), 64'(v.exp_v));
        chk({tag, "_norm"}, 64'(norm_out), 64'(v.norm_v));
        chk({tag, "_zero"}, 64'(zero_out), 64'(v.zero_v));
        chk({tag, "_norm_msb"}, 64'(norm_out[16]), 64'd1);
    endtask

    task automatic handshake(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int n;
        vec_t v;
        logic [5:0]  cap_exp;
        logic [16:0] cap_norm;
        logic        cap_zero;

        vecs[0] = '{48'h1,              6'd0,  17'h10000, 1'b0};
        vecs[1] = '{48'h8000_0000_0000, 6'd47, 17'h10000, 1'b0};
        vecs[2] = '{48'hFFFF_FFFF_FFFF, 6'd47, 17'h1FFFF, 1'b0};
        vecs[3] = '{48'h3,              6'd1,  17'h18000, 1'b0};
        vecs[4] = '{48'h0000_0001_8001, 6'd16, 17'h18001, 1'b0};
        vecs[5] = '{48'h0,              6'd0,  17'h10000, 1'b1};
        vecs[6] = '{48'h400,            6'd10, 17'h10000, 1'b0};
        vecs[7] = '{48'h0000_A5A5_0000, 6'd31, 17'h14B4A, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_norm", 64'(norm_out), 64'd0);
        chk("rst_exp", 64'(exp_out), 64'd0);
        chk("rst_zero", 64'(zero_out), 64'd0);

        for (int i = 0; i < 8; i++) begin
            accept(vecs[i].data, 1'b0);
            wait_valid(n);
            check_result($sformatf("vec%0d", i), vecs[i], n);
            handshake($sformatf("vec%0d", i));
        end

        // Backpressure: result must hold and new data must not be taken.
        out_ready = 1'b0;
        accept(48'h3, 1'b1);
        data_in = 48'hFFFF_FFFF_FFFF;
        wait_valid(n);
        check_result("bp_first", vecs[3], n);
        cap_exp  = exp_out;
        cap_norm = norm_out;
        cap_zero = zero_out;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_ready", 64'(in_ready), 64'd0);
            chk("bp_hold_exp", 64'(exp_out), 64'(cap_exp));
            chk("bp_hold_norm", 64'(norm_out), 64'(cap_norm));
            chk("bp_hold_zero", 64'(zero_out), 64'(cap_zero));
        end
        out_ready = 1'b1;
        handshake("bp");
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(n);
        check_result("bp_second", vecs[2], n);
        handshake("bp_second");

        // Reset in the middle of the search drops the sample.
        accept(48'h3, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_valid", 64'(out_valid), 64'd0);
        end
        accept(48'h400, 1'b0);
        wait_valid(n);
        check_result("post_abort", vecs[6], n);
        handshake("post_abort");

        // Zero input while out_ready starts low, then released.
        out_ready = 1'b0;
        accept(48'h0, 1'b0);
        wait_valid(n);
        v = vecs[5];
        check_result("zero_bp", v, n);
        out_ready = 1'b1;
        handshake("zero_bp");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
